// File: rtl/phase_seq.sv
// One-hot instruction phase sequencer with reset-release start, halt/restart, skip and stall.
// Latency: all outputs registered; a control input takes effect on the next rising clk edge.
// Backpressure: stall (or, with PHASE_SEQ_STEP_EN and step_mode, the absence of step) holds the phase.
// Optional feature macro: PHASE_SEQ_STEP_EN adds step_mode/step single-step inputs.
module phase_seq #(
   parameter int NPHASE = 5,
   parameter int SYNC_N = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              hlt,
   input  logic              restart,
   input  logic              stall,
   input  logic              skip,
`ifdef PHASE_SEQ_STEP_EN
   input  logic              step_mode,
   input  logic              step,
`endif
   output logic [NPHASE-1:0] phase,
   output logic              busy,
   output logic              instr_done,
   output logic [CNT_W-1:0]  instr_cnt
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [NPHASE-1:0] PH_FIRST = NPHASE'(1);

   logic [SYNC_N-1:0] sync_q, sync_d;
   logic [1:0]        state_q, state_d;
   logic [NPHASE-1:0] phase_q, phase_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              start_evt;
   logic              adv_en;

   // Reset-release synchroniser: ones shift in from the LSB after n_rst rises.
   assign sync_d    = {sync_q[SYNC_N-2:0], 1'b1};
   // The 0->1 boundary reaching the top two stages marks the single start event.
   assign start_evt = !sync_q[SYNC_N-1] && sync_q[SYNC_N-2];

`ifdef PHASE_SEQ_STEP_EN
   // In step mode the sequencer only advances in cycles carrying a step pulse.
   assign adv_en = !step_mode || step;
`else
   assign adv_en = 1'b1;
`endif

   // Next-state decode in priority order: hlt, restart, start, skip, stall/no-step, rotate.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      if (hlt) begin
         state_d = ST_HALT;
         phase_d = '0;
         busy_d  = 1'b0;
      end else if (restart && (state_q == ST_HALT)) begin
         state_d = ST_RUN;
         phase_d = PH_FIRST;
         busy_d  = 1'b1;
      end else if (start_evt && (state_q == ST_IDLE)) begin
         state_d = ST_RUN;
         phase_d = PH_FIRST;
         busy_d  = 1'b1;
      end else if (state_q == ST_RUN) begin
         if (skip && adv_en && !phase_q[0]) begin
            // Early end of instruction: back to the first phase, counts as completion.
            phase_d = PH_FIRST;
            done_d  = 1'b1;
         end else if (stall || !adv_en) begin
            phase_d = phase_q;
         end else begin
            phase_d = {phase_q[NPHASE-2:0], phase_q[NPHASE-1]};
            done_d  = phase_q[NPHASE-1];
         end
      end
      if (done_d) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // State and output registers, cleared asynchronously by n_rst.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         sync_q  <= '0;
         state_q <= ST_IDLE;
         phase_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         phase_q <= phase_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign phase      = phase_q;
   assign busy       = busy_q;
   assign instr_done = done_q;
   assign instr_cnt  = cnt_q;

endmodule
